// File: rtl/multdiv_ctrl_pkg.sv
// Shared decode constants, rstatus codes and FSM encoding for the mul/div sequencer.
package multdiv_ctrl_pkg;

  localparam logic [4:0] OPC_RTYPE   = 5'b00000;
  localparam logic [4:0] ALU_MUL     = 5'b00110;
  localparam logic [4:0] ALU_DIV     = 5'b00111;
  localparam logic [4:0] REG_RSTATUS = 5'd30;
  localparam logic [4:0] RSTATUS_MUL = 5'd4;
  localparam logic [4:0] RSTATUS_DIV = 5'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [4:0] rstatus_code(input logic is_div);
    if (is_div) begin
      return RSTATUS_DIV;
    end else begin
      return RSTATUS_MUL;
    end
  endfunction

endpackage

// File: rtl/multdiv_watchdog.sv
// Clearable cycle counter that flags when the multdiv unit has used its whole wait budget.
module multdiv_watchdog #(
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count_r;

  // Wait counter: clear has priority over count enable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (en) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Execute-stage sequencer for the shared iterative multiplier/divider: stalls the pipeline,
// launches the unit, waits under a watchdog and emits a single writeback beat.
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             insn_valid,
  input  logic [4:0]       opcode,
  input  logic [4:0]       aluop,
  input  logic [4:0]       rd,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             unit_rdy,
  input  logic [WIDTH-1:0] unit_res,
  input  logic             unit_exc,
  output logic             ctrl_mult,
  output logic             ctrl_div,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  output logic             stall,
  output logic             wb_en,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data
);

  state_e           state_r;
  logic             is_div_r;
  logic [4:0]       rd_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             ctrl_mult_r;
  logic             ctrl_div_r;
  logic             busy_stall_r;
  logic             wb_en_r;
  logic [4:0]       wb_rd_r;
  logic [WIDTH-1:0] wb_data_r;

  logic is_mul_s;
  logic is_div_s;
  logic start_req_s;
  logic wd_clr_s;
  logic wd_en_s;
  logic wd_tc_s;

  assign is_mul_s    = (opcode == OPC_RTYPE) && (aluop == ALU_MUL);
  assign is_div_s    = (opcode == OPC_RTYPE) && (aluop == ALU_DIV);
  assign start_req_s = insn_valid && (is_mul_s || is_div_s);

  assign wd_clr_s = (state_r == ST_START);
  assign wd_en_s  = (state_r == ST_BUSY);

  multdiv_watchdog #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clock(clock),
    .reset(reset),
    .clr  (wd_clr_s),
    .en   (wd_en_s),
    .tc   (wd_tc_s)
  );

  // Sequencer FSM; every output except the IDLE-cycle stall is registered here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      is_div_r     <= 1'b0;
      rd_r         <= 5'd0;
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      ctrl_mult_r  <= 1'b0;
      ctrl_div_r   <= 1'b0;
      busy_stall_r <= 1'b0;
      wb_en_r      <= 1'b0;
      wb_rd_r      <= 5'd0;
      wb_data_r    <= {WIDTH{1'b0}};
    end else begin
      ctrl_mult_r <= 1'b0;
      ctrl_div_r  <= 1'b0;
      wb_en_r     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_req_s) begin
            a_r          <= op_a;
            b_r          <= op_b;
            rd_r         <= rd;
            is_div_r     <= is_div_s;
            ctrl_mult_r  <= is_mul_s;
            ctrl_div_r   <= is_div_s;
            busy_stall_r <= 1'b1;
            state_r      <= ST_START;
          end
        end
        ST_START: begin
          state_r <= ST_BUSY;
        end
        ST_BUSY: begin
          // A result arriving on the last budgeted cycle still wins over the timeout.
          if (unit_rdy) begin
            wb_en_r      <= 1'b1;
            busy_stall_r <= 1'b0;
            state_r      <= ST_DONE;
            if (unit_exc) begin
              wb_rd_r   <= REG_RSTATUS;
              wb_data_r <= WIDTH'(rstatus_code(is_div_r));
            end else begin
              wb_rd_r   <= rd_r;
              wb_data_r <= unit_res;
            end
          end else if (wd_tc_s) begin
            wb_en_r      <= 1'b1;
            busy_stall_r <= 1'b0;
            state_r      <= ST_DONE;
            wb_rd_r      <= REG_RSTATUS;
            wb_data_r    <= WIDTH'(rstatus_code(is_div_r));
          end
        end
        ST_DONE: begin
          wb_rd_r   <= 5'd0;
          wb_data_r <= {WIDTH{1'b0}};
          state_r   <= ST_IDLE;
        end
        default: begin
          busy_stall_r <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign stall     = busy_stall_r || ((state_r == ST_IDLE) && start_req_s);
  assign ctrl_mult = ctrl_mult_r;
  assign ctrl_div  = ctrl_div_r;
  assign unit_a    = a_r;
  assign unit_b    = b_r;
  assign wb_en     = wb_en_r;
  assign wb_rd     = wb_rd_r;
  assign wb_data   = wb_data_r;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: the bench plays the multdiv unit and predicts
// stall/pulse/writeback timing from the op's arithmetic and the ready delay.
module tb_multdiv_ctrl;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 40;
  localparam int CNT_W   = 6;

  logic             clock = 1'b0;
  logic             reset;
  logic             insn_valid;
  logic [4:0]       opcode, aluop, rd;
  logic [WIDTH-1:0] op_a, op_b;
  logic             unit_rdy;
  logic [WIDTH-1:0] unit_res;
  logic             unit_exc;
  logic             ctrl_mult, ctrl_div, stall, wb_en;
  logic [WIDTH-1:0] unit_a, unit_b, wb_data;
  logic [4:0]       wb_rd;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  multdiv_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .insn_valid(insn_valid), .opcode(opcode), .aluop(aluop),
    .rd(rd), .op_a(op_a), .op_b(op_b), .unit_rdy(unit_rdy), .unit_res(unit_res),
    .unit_exc(unit_exc), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .unit_a(unit_a),
    .unit_b(unit_b), .stall(stall), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  // One mul/div from presentation to writeback. k = BUSY cycle carrying unit_rdy, 0 = never.
  task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd_v, input int k, input bit noise);
    logic [63:0] prod;
    logic [31:0] res_in, exp_data;
    logic [4:0]  exp_rd;
    logic        exc_in, exp_exc, exp_bit;
    bit          timed_out;
    int          kk;
    prod = {32'd0, a} * {32'd0, b};
    if (is_div) begin
      exc_in = (b == 32'd0);
      res_in = (b == 32'd0) ? 32'd0 : a / b;
    end else begin
      exc_in = (prod[63:32] != 32'd0);
      res_in = prod[31:0];
    end
    timed_out = (k == 0);
    kk        = timed_out ? TIMEOUT : k;
    exp_exc   = timed_out || exc_in;
    exp_rd    = exp_exc ? 5'd30 : rd_v;
    exp_data  = exp_exc ? (is_div ? 32'd5 : 32'd4) : res_in;
    for (int c = 0; c <= kk + 2; c++) begin
      @(negedge clock);
      insn_valid = 1'b1;
      opcode     = 5'b00000;
      aluop      = is_div ? 5'b00111 : 5'b00110;
      if (c == 0) begin
        rd = rd_v; op_a = a; op_b = b;
      end else begin
        rd = 5'($urandom); op_a = $urandom; op_b = $urandom;
      end
      if (!timed_out && c == kk + 1) begin
        unit_rdy = 1'b1; unit_res = res_in; unit_exc = exc_in;
      end else begin
        unit_rdy = noise && (c <= 1); unit_res = $urandom; unit_exc = 1'($urandom);
      end
      #1;
      exp_bit = (c <= kk + 1);
      checks++;
      if (stall !== exp_bit) begin
        errors++; $display("FAIL stall c=%0d: got %b expected %b", c, stall, exp_bit);
      end
      exp_bit = (c == 1) && !is_div;
      checks++;
      if (ctrl_mult !== exp_bit) begin
        errors++; $display("FAIL ctrl_mult c=%0d: got %b expected %b", c, ctrl_mult, exp_bit);
      end
      exp_bit = (c == 1) && is_div;
      checks++;
      if (ctrl_div !== exp_bit) begin
        errors++; $display("FAIL ctrl_div c=%0d: got %b expected %b", c, ctrl_div, exp_bit);
      end
      exp_bit = (c == kk + 2);
      checks++;
      if (wb_en !== exp_bit) begin
        errors++; $display("FAIL wb_en c=%0d: got %b expected %b", c, wb_en, exp_bit);
      end
      if (c >= 1) begin
        checks++;
        if (unit_a !== a || unit_b !== b) begin
          errors++;
          $display("FAIL operands c=%0d: got %h/%h expected %h/%h", c, unit_a, unit_b, a, b);
        end
      end
      if (c == kk + 2) begin
        checks++;
        if (wb_rd !== exp_rd) begin
          errors++; $display("FAIL wb_rd: got %0d expected %0d", wb_rd, exp_rd);
        end
        checks++;
        if (wb_data !== exp_data) begin
          errors++; $display("FAIL wb_data: got %h expected %h", wb_data, exp_data);
        end
      end
    end
  endtask

  // Cycles with no valid instruction; stray ready pulses must not cause a writeback.
  task automatic idle_cycles(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      insn_valid = 1'b0;
      unit_rdy   = noise ? 1'($urandom) : 1'b0;
      unit_res   = $urandom;
      unit_exc   = 1'($urandom);
      #1;
      checks++;
      if (stall !== 1'b0 || wb_en !== 1'b0) begin
        errors++; $display("FAIL idle: got stall=%b wb_en=%b expected 0/0", stall, wb_en);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; insn_valid = 1'b0; opcode = 5'd0; aluop = 5'd0; rd = 5'd0;
    op_a = 32'd0; op_b = 32'd0; unit_rdy = 1'b0; unit_res = 32'd0; unit_exc = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if ({stall, ctrl_mult, ctrl_div, wb_en, wb_rd, wb_data, unit_a, unit_b} !== '0) begin
      errors++;
      $display("FAIL reset: got stall=%b cm=%b cd=%b wb=%b rd=%0d data=%h a=%h b=%h expected all 0",
               stall, ctrl_mult, ctrl_div, wb_en, wb_rd, wb_data, unit_a, unit_b);
    end
    reset = 1'b0;
    idle_cycles(2, 1'b0);
  endtask

  task automatic test_mul_basic();
    run_op(1'b0, 32'd7, 32'd6, 5'd9, 32, 1'b0);
    idle_cycles(2, 1'b0);
  endtask

  task automatic test_div_basic();
    run_op(1'b1, 32'd100, 32'd7, 5'd12, 3, 1'b0);
    idle_cycles(1, 1'b0);
  endtask

  task automatic test_exceptions();
    run_op(1'b1, 32'd55, 32'd0, 5'd4, 5, 1'b0);
    idle_cycles(1, 1'b0);
    run_op(1'b0, 32'h0001_0000, 32'h0002_0000, 5'd5, 1, 1'b0);
    idle_cycles(1, 1'b0);
  endtask

  task automatic test_timeout();
    run_op(1'b0, 32'd3, 32'd4, 5'd7, 0, 1'b1);
    idle_cycles(1, 1'b0);
    run_op(1'b1, 32'd90, 32'd9, 5'd8, 0, 1'b1);
    idle_cycles(3, 1'b1);
    run_op(1'b1, 32'd81, 32'd9, 5'd17, TIMEOUT, 1'b0);
    idle_cycles(1, 1'b0);
  endtask

  task automatic test_ignored();
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      insn_valid = (i == 7) ? 1'b0 : 1'b1;
      opcode     = (i < 4 || i == 7) ? 5'd0 : 5'($urandom);
      aluop      = (i == 7) ? 5'b00110 : 5'($urandom);
      if (insn_valid && opcode == 5'd0 && (aluop == 5'b00110 || aluop == 5'b00111))
        aluop = 5'd0;
      unit_rdy = 1'($urandom);
      #1;
      checks++;
      if ({stall, ctrl_mult, ctrl_div, wb_en} !== 4'b0000) begin
        errors++;
        $display("FAIL ignored op=%0d alu=%0d: got %b%b%b%b expected 0000",
                 opcode, aluop, stall, ctrl_mult, ctrl_div, wb_en);
      end
    end
    idle_cycles(1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      run_op(1'($urandom), $urandom_range(2000, 0), $urandom_range(60, 0),
             5'($urandom), int'($urandom_range(TIMEOUT, 0)), 1'($urandom));
      idle_cycles(int'($urandom_range(2, 0)), 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    run_op(1'b0, 32'd11, 32'd13, 5'd3, 4, 1'b0);
    run_op(1'b1, 32'd1000, 32'd33, 5'd6, 2, 1'b0);
    idle_cycles(1, 1'b0);
  endtask

  task automatic test_reset_mid_busy();
    for (int c = 0; c <= 6; c++) begin
      @(negedge clock);
      insn_valid = 1'b1; opcode = 5'd0; aluop = 5'b00110; rd = 5'd21;
      op_a = 32'd5; op_b = 32'd5; unit_rdy = 1'b0;
    end
    #3;
    reset = 1'b1; insn_valid = 1'b0;
    #1;
    checks++;
    if ({stall, ctrl_mult, ctrl_div, wb_en, wb_rd, wb_data, unit_a, unit_b} !== '0) begin
      errors++;
      $display("FAIL async reset: got stall=%b wb=%b a=%h b=%h expected all 0",
               stall, wb_en, unit_a, unit_b);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    idle_cycles(3, 1'b1);
    run_op(1'b0, 32'd12, 32'd12, 5'd21, 6, 1'b0);
    idle_cycles(1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_div_basic();
    test_exceptions();
    test_timeout();
    test_ignored();
    test_random();
    test_back_to_back();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
